// File: rtl/counter_pkg.sv
// Shared definitions for the display counter family (up-counter and countdown_30).
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [7:0]  COUNT_MAX               = 8'd99;
  localparam logic [23:0] DEFAULT_TICKS_PER_COUNT = 24'd10_000_000;

  // The two-digit display cannot show anything above COUNT_MAX.
  function automatic logic [7:0] clip_count(input logic [7:0] value);
    return (value > COUNT_MAX) ? COUNT_MAX : value;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a single-cycle tick every TICKS_PER_COUNT enabled cycles.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter logic [23:0] TICKS_PER_COUNT = DEFAULT_TICKS_PER_COUNT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [23:0] cnt;
  logic        at_wrap;

  assign at_wrap = (cnt == TICKS_PER_COUNT - 24'd1);
  assign tick    = en && at_wrap;

  // When not enabled and not cleared the count holds, which is what lets a pause resume mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 24'd0;
    end else if (clr) begin
      cnt <= 24'd0;
    end else if (en) begin
      cnt <= at_wrap ? 24'd0 : cnt + 24'd1;
    end
  end

endmodule

// File: rtl/countdown_30.sv
// Presettable countdown timer for the two-digit display, with expiry pulse or auto-reload.
module countdown_30
  import counter_pkg::*;
#(
  parameter logic [23:0] TICKS_PER_COUNT = DEFAULT_TICKS_PER_COUNT,
  parameter logic [7:0]  START_VALUE     = 8'd30,
  parameter bit          AUTO_RELOAD     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] count,
  output logic       running,
  output logic       done,
  output logic       expired
);

  state_t     state;
  logic [7:0] preset;
  logic       tick;
  logic       presc_en;
  logic       presc_clr;

  assign presc_en  = (state == RUN);
  assign presc_clr = load || (state == IDLE) || (state == EXPIRED);

  tick_prescaler #(
    .TICKS_PER_COUNT(TICKS_PER_COUNT)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= START_VALUE;
      preset  <= START_VALUE;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        preset  <= clip_count(load_value);
        count   <= clip_count(load_value);
        state   <= IDLE;
        running <= 1'b0;
        expired <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_stop) begin
              if (count != 8'd0) begin
                state   <= RUN;
                running <= 1'b1;
              end else begin
                state   <= EXPIRED;
                expired <= 1'b1;
              end
            end
          end
          RUN: begin
            if (!start_stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end
            // A tick coinciding with a pause still counts; reaching zero overrides the pause.
            if (tick) begin
              if (count > 8'd1) begin
                count <= count - 8'd1;
              end else if (count == 8'd1) begin
                count <= 8'd0;
                done  <= 1'b1;
                if (!AUTO_RELOAD) begin
                  state   <= EXPIRED;
                  running <= 1'b0;
                  expired <= 1'b1;
                end
              end else begin
                count <= preset;
              end
            end
          end
          PAUSE: begin
            if (start_stop) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          EXPIRED: begin
            count <= 8'd0;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_30.sv
// Directed bench for countdown_30: one expiring and one auto-reloading instance against a behavioural model.
module tb_countdown_30;

  localparam int TICKS = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  typedef struct {
    int count;
    int preset;
    int elapsed;
    int mode;
    bit done;
  } model_t;

  logic       clk;
  logic       rst_n;
  logic       start_stop, load;
  logic [7:0] load_value;
  logic [7:0] count;
  logic       running, done, expired;
  logic       start_stop_ar, load_ar;
  logic [7:0] load_value_ar;
  logic [7:0] count_ar;
  logic       running_ar, done_ar, expired_ar;

  int     checks   = 0;
  int     failures = 0;
  bit     compare_en = 1'b0;
  model_t m, mar;

  countdown_30 #(.TICKS_PER_COUNT(24'd4), .START_VALUE(8'd30), .AUTO_RELOAD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .load(load), .load_value(load_value),
    .count(count), .running(running), .done(done), .expired(expired)
  );

  countdown_30 #(.TICKS_PER_COUNT(24'd4), .START_VALUE(8'd30), .AUTO_RELOAD(1'b1)) dut_ar (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop_ar), .load(load_ar), .load_value(load_value_ar),
    .count(count_ar), .running(running_ar), .done(done_ar), .expired(expired_ar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic model_t model_reset();
    model_t r;
    r.count = 30; r.preset = 30; r.elapsed = 0; r.mode = M_IDLE; r.done = 1'b0;
    return r;
  endfunction

  // elapsed = cycles spent running in the current period; a period ends after TICKS of them.
  function automatic model_t model_next(model_t cur, bit ss, bit ld, int lv, bit ar);
    model_t n = cur;
    bit period_end = (cur.mode == M_RUN) && (cur.elapsed == TICKS - 1);
    n.done = 1'b0;
    if (ld || cur.mode == M_IDLE || cur.mode == M_EXP) n.elapsed = 0;
    else if (cur.mode == M_RUN) n.elapsed = period_end ? 0 : cur.elapsed + 1;
    if (ld) begin
      n.preset = (lv > 99) ? 99 : lv;
      n.count  = n.preset;
      n.mode   = M_IDLE;
    end else begin
      case (cur.mode)
        M_IDLE:  if (ss) n.mode = (cur.count != 0) ? M_RUN : M_EXP;
        M_RUN: begin
          if (!ss) n.mode = M_PAUSE;
          if (period_end) begin
            if (cur.count == 1) begin
              n.count = 0;
              n.done  = 1'b1;
              if (!ar) n.mode = M_EXP;
            end else if (cur.count == 0) n.count = cur.preset;
            else n.count = cur.count - 1;
          end
        end
        M_PAUSE: if (ss) n.mode = M_RUN;
        default: n.count = 0;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   = model_reset();
      mar = model_reset();
    end else begin
      m   = model_next(m, start_stop, load, int'(load_value), 1'b0);
      mar = model_next(mar, start_stop_ar, load_ar, int'(load_value_ar), 1'b1);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("model_count",      count,      m.count);
      checkOutput("model_running",    running,    m.mode == M_RUN);
      checkOutput("model_done",       done,       m.done);
      checkOutput("model_expired",    expired,    m.mode == M_EXP);
      checkOutput("model_ar_count",   count_ar,   mar.count);
      checkOutput("model_ar_running", running_ar, mar.mode == M_RUN);
      checkOutput("model_ar_done",    done_ar,    mar.done);
      checkOutput("model_ar_expired", expired_ar, mar.mode == M_EXP);
    end
  end

  task automatic applyStimulus(input logic ss, input logic ld, input logic [7:0] lv);
    start_stop = ss;
    load       = ld;
    load_value = lv;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0);
    start_stop_ar = 1'b0; load_ar = 1'b0; load_value_ar = 8'd0;
    #1 rst_n = 1'b0;
    wait_n(3);
    compare_en = 1'b1;
    checkOutput("reset_count", count, 30);
    checkOutput("reset_running", running, 0);
    checkOutput("reset_expired", expired, 0);

    // Reset then run: first decrement 4 cycles after RUN entry.
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd0);
    wait_n(4);
    checkOutput("run_hold30", count, 30);
    checkOutput("run_running", running, 1);
    wait_n(1);
    checkOutput("run_first_dec", count, 29);
    wait_n(4);
    checkOutput("run_second_dec", count, 28);

    // Pause two cycles into a period.
    wait_n(2);
    applyStimulus(1'b0, 1'b0, 8'd0);
    wait_n(20);
    checkOutput("pause_frozen", count, 28);
    checkOutput("pause_running", running, 0);
    applyStimulus(1'b1, 1'b0, 8'd0);
    wait_n(1);
    checkOutput("resume_nodec", count, 28);
    wait_n(1);
    checkOutput("resume_dec", count, 27);

    // Expiry from a preset of 2.
    applyStimulus(1'b1, 1'b1, 8'd2);
    wait_n(1);
    checkOutput("exp_loaded", count, 2);
    applyStimulus(1'b1, 1'b0, 8'd0);
    wait_n(5);
    checkOutput("exp_one", count, 1);
    wait_n(4);
    checkOutput("exp_zero", count, 0);
    checkOutput("exp_done_pulse", done, 1);
    checkOutput("exp_expired", expired, 1);
    wait_n(1);
    checkOutput("exp_done_clear", done, 0);
    applyStimulus(1'b0, 1'b0, 8'd0);
    wait_n(3);
    applyStimulus(1'b1, 1'b0, 8'd0);
    wait_n(3);
    checkOutput("exp_sticky", expired, 1);
    checkOutput("exp_not_running", running, 0);

    // Load of 150 coinciding with a tick.
    applyStimulus(1'b1, 1'b1, 8'd30);
    wait_n(1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    wait_n(1);
    checkOutput("prio_running", running, 1);
    wait_n(3);
    applyStimulus(1'b1, 1'b1, 8'd150);
    wait_n(1);
    checkOutput("prio_clip", count, 99);
    checkOutput("prio_idle", running, 0);
    applyStimulus(1'b0, 1'b0, 8'd0);
    wait_n(6);
    checkOutput("prio_hold", count, 99);

    // Load of zero then start goes straight to EXPIRED.
    applyStimulus(1'b0, 1'b1, 8'd0);
    wait_n(1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    wait_n(1);
    checkOutput("zero_expired", expired, 1);
    checkOutput("zero_no_done", done, 0);

    // Auto-reload instance: 3,2,1,0,3,2...
    load_ar = 1'b1; load_value_ar = 8'd3;
    wait_n(1);
    checkOutput("ar_loaded", count_ar, 3);
    load_ar = 1'b0; start_stop_ar = 1'b1;
    wait_n(5);
    checkOutput("ar_two", count_ar, 2);
    wait_n(4);
    checkOutput("ar_one", count_ar, 1);
    wait_n(4);
    checkOutput("ar_zero", count_ar, 0);
    checkOutput("ar_done", done_ar, 1);
    checkOutput("ar_not_expired", expired_ar, 0);
    wait_n(4);
    checkOutput("ar_reload", count_ar, 3);
    wait_n(4);
    checkOutput("ar_two_again", count_ar, 2);
    checkOutput("ar_still_running", running_ar, 1);

    // Asynchronous reset while counting at 17.
    applyStimulus(1'b0, 1'b1, 8'd30);
    wait_n(1);
    applyStimulus(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 300 && m.count != 17; i++) wait_n(1);
    checkOutput("mid_reached17", count, 17);
    wait_n(1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_count", count, 30);
    checkOutput("mid_rst_running", running, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_expired", expired, 0);
    checkOutput("mid_rst_ar_count", count_ar, 30);
    wait_n(2);
    applyStimulus(1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    wait_n(3);
    checkOutput("post_rst_idle", count, 30);
    applyStimulus(1'b1, 1'b0, 8'd0);
    wait_n(5);
    checkOutput("post_rst_dec", count, 29);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
